// File: rtl/datapath_executor.sv
// datapath_executor
//
// Executes one command at a time for the draw/sequencing clients over the
// start/instruction/finished/result handshake.  A command is decoded and
// serviced against the single-port simulation RAM (MEMREAD / MEMWRITE) or the
// VGA pixel-write port (DRAW).  Opcodes 0 and 4..15 complete with no effect.
//
// Ports
//   clock        system clock, all logic on posedge
//   reset        synchronous, active-high
//   start        command request from the client (held high for two cycles)
//   instruction  command word, opcode in [31:28], captured only on accept
//   finished     high while idle / once the last command has completed
//   result       data returned by the last completed MEMREAD
//   mem_address  RAM address (holds between commands)
//   mem_data     RAM write data (holds between commands)
//   mem_write    RAM write enable, single-cycle pulse
//   mem_q        RAM read data, registered by the RAM
//   vga_x/vga_y/vga_colour  pixel coordinates and colour (hold between commands)
//   vga_plot     pixel write strobe, single-cycle pulse
module datapath_executor #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH    = 16,
   parameter int RESULT_WIDTH      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [INSTRUCTION_WIDTH-1:0]  instruction,
   output logic                          finished,
   output logic [RESULT_WIDTH-1:0]       result,
   output logic [MEM_ADDR_WIDTH-1:0]     mem_address,
   output logic [15:0]                   mem_data,
   output logic                          mem_write,
   input  logic [15:0]                   mem_q,
   output logic [7:0]                    vga_x,
   output logic [6:0]                    vga_y,
   output logic [2:0]                    vga_colour,
   output logic                          vga_plot
);

   typedef enum logic [2:0] {IDLE, EXEC, RD_WAIT, RD_CAPTURE, DONE} state_t;

   localparam logic [3:0] OP_MEMREAD  = 4'd1;
   localparam logic [3:0] OP_MEMWRITE = 4'd2;
   localparam logic [3:0] OP_DRAW     = 4'd3;

   state_t                         state;
   state_t                         next_state;
   logic                           armed;
   logic                           armed_d;
   logic [INSTRUCTION_WIDTH-1:0]   instr_q;
   logic [INSTRUCTION_WIDTH-1:0]   instr_d;
   logic [3:0]                     opcode;
   logic                           accept;
   logic                           draw_visible;

   logic                           finished_d;
   logic [RESULT_WIDTH-1:0]        result_d;
   logic [MEM_ADDR_WIDTH-1:0]      mem_address_d;
   logic [15:0]                    mem_data_d;
   logic                           mem_write_d;
   logic [7:0]                     vga_x_d;
   logic [6:0]                     vga_y_d;
   logic [2:0]                     vga_colour_d;
   logic                           vga_plot_d;

   assign opcode = instr_q[INSTRUCTION_WIDTH-1 -: 4];

   // A start level only launches a command after it has been seen low at
   // least once since the previous accept, so a client still holding start
   // from the last command cannot trigger a second one.
   assign accept = (state == IDLE) && start && armed;

   // Pixels outside the 160x120 screen, or with the plot bit clear, update
   // the coordinate registers but never strobe the adapter.
   assign draw_visible = instr_q[18] && (instr_q[7:0] < 8'd160) && (instr_q[14:8] < 7'd120);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: reads take two extra cycles to let the RAM's
   // registered output settle before capture.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (accept) next_state = EXEC;
         EXEC:       next_state = (opcode == OP_MEMREAD) ? RD_WAIT : DONE;
         RD_WAIT:    next_state = RD_CAPTURE;
         RD_CAPTURE: next_state = DONE;
         DONE:       next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   // Output/datapath next values.  Everything holds by default; strobes
   // default low so they can only ever be high for the single EXEC cycle.
   // For reads, finished is raised together with the captured result so the
   // client sees the data the moment completion is reported.
   always_comb begin
      armed_d       = armed;
      instr_d       = instr_q;
      finished_d    = finished;
      result_d      = result;
      mem_address_d = mem_address;
      mem_data_d    = mem_data;
      mem_write_d   = 1'b0;
      vga_x_d       = vga_x;
      vga_y_d       = vga_y;
      vga_colour_d  = vga_colour;
      vga_plot_d    = 1'b0;

      if (accept) begin
         armed_d = 1'b0;
      end else if (!start) begin
         armed_d = 1'b1;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               instr_d    = instruction;
               finished_d = 1'b0;
            end
         end
         EXEC: begin
            case (opcode)
               OP_MEMREAD: begin
                  mem_address_d = instr_q[MEM_ADDR_WIDTH-1:0];
               end
               OP_MEMWRITE: begin
                  mem_address_d = instr_q[MEM_ADDR_WIDTH-1:0];
                  mem_data_d    = {4'b0000, instr_q[27:16]};
                  mem_write_d   = 1'b1;
               end
               OP_DRAW: begin
                  vga_x_d      = instr_q[7:0];
                  vga_y_d      = instr_q[14:8];
                  vga_colour_d = instr_q[17:15];
                  vga_plot_d   = draw_visible;
               end
               default: begin
               end
            endcase
         end
         RD_CAPTURE: begin
            result_d   = RESULT_WIDTH'(mem_q);
            finished_d = 1'b1;
         end
         DONE: begin
            finished_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output registers.  Reset aborts any command in flight without signalling
   // a completion beyond returning to the idle state.
   always_ff @(posedge clock) begin
      if (reset) begin
         armed       <= 1'b1;
         instr_q     <= '0;
         finished    <= 1'b1;
         result      <= '0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_write   <= 1'b0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
         vga_plot    <= 1'b0;
      end else begin
         armed       <= armed_d;
         instr_q     <= instr_d;
         finished    <= finished_d;
         result      <= result_d;
         mem_address <= mem_address_d;
         mem_data    <= mem_data_d;
         mem_write   <= mem_write_d;
         vga_x       <= vga_x_d;
         vga_y       <= vga_y_d;
         vga_colour  <= vga_colour_d;
         vga_plot    <= vga_plot_d;
      end
   end

endmodule

// File: doc/datapath_executor.md
# datapath_executor

Executes one-command-at-a-time instructions issued by the drawing/sequencing FSMs (ant, food and similar draw stages) over the shared `start_dp`/`instruction_dp`/`finished_dp`/`result_dp` handshake. Decodes the instruction and services it against the single-port simulation RAM (MEMREAD/MEMWRITE) or the VGA pixel-write port (DRAW). Sits directly downstream of the draw FSMs, behind the client arbiter mux, and upstream of the RAM and VGA adapter.

## Interface
- INSTRUCTION_WIDTH, 32, instruction bus width; opcode is [31:28].
- MEM_ADDR_WIDTH, 16, RAM address width.
- RESULT_WIDTH, 16, result bus width.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command request from client.
- instruction  in  32  command word; sampled only on accept.
- finished  out  1  high = idle / result valid.
- result  out  16  result of last MEMREAD; holds until next MEMREAD completes.
- mem_address  out  16  RAM address.
- mem_data  out  16  RAM write data.
- mem_write  out  1  RAM write enable, one-cycle pulse.
- mem_q  in  16  RAM read data; valid 2 cycles after address is presented.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write strobe, one-cycle pulse.

## Operation
- Opcodes ([31:28]): 0 NOP, 1 MEMREAD, 2 MEMWRITE, 3 DRAW; 4–15 are treated as NOP.
- MEMREAD: address = [15:0]; [27:16] ignored. result <= mem_q zero-extended to 16 bits.
- MEMWRITE: address = [15:0]; data = [27:16] zero-extended to 16 bits.
- DRAW: x = [7:0], y = [14:8], colour = [17:15], plot = [18]; [27:19] ignored.
- States: IDLE, EXEC, RD_WAIT, RD_CAPTURE, DONE.
- IDLE: finished = 1. Accept when start = 1 and armed = 1.
  - On accept: latch instruction, clear armed, finished <= 0, go to EXEC.
  - armed <= 1 whenever start is sampled 0 in any state.
- Re-trigger rule: clients hold start high for two cycles. A start level still high after completion must not launch a second command.
- EXEC:
  - MEMREAD: drive mem_address, go to RD_WAIT.
  - MEMWRITE: drive address and data, pulse mem_write, go to DONE.
  - DRAW: drive vga_x/y/colour, pulse vga_plot, go to DONE. vga_plot is suppressed when plot = 0, x ≥ 160 or y ≥ 120.
  - NOP / unknown: go to DONE with no side effects.
- RD_WAIT: go to RD_CAPTURE.
- RD_CAPTURE: result <= mem_q, go to DONE.
- DONE: finished <= 1, go to IDLE.
- mem_address, vga_x/y/colour hold their last driven value between commands.
- result changes only in RD_CAPTURE.

## Timing
- Reset (synchronous, active-high) forces:
  - state = IDLE, armed = 1, finished = 1.
  - result = 0, mem_address = 0, mem_data = 0, mem_write = 0.
  - vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0.
- Reset asserted mid-command aborts the command. Strobes are low from the first cycle after reset is sampled; no completion is signalled.
- Latency, with accept sampled at edge T:
  - finished = 0 from T+1.
  - MEMREAD: mem_address valid from T+2; result updated and finished = 1 at T+4.
  - MEMWRITE and DRAW: mem_write / vga_plot high during T+2 only; finished = 1 at T+3.
  - NOP: finished = 1 at T+3.
- finished is low no later than the first cycle a two-cycle-start client samples it, so stale completion is never observed.
- start asserted while busy is ignored, though a low sample still re-arms.

## Test plan
- Reset, then idle: all outputs at their reset values, finished = 1, no strobes.
- RAM[0x0040] = 0x0023; MEMREAD 0x1000_0040 with start held 2 cycles -> finished low at T+1, result = 0x0023 and finished high at T+4, exactly one command executed.
- DRAW 0x3004_3A15 (plot = 1, colour = 0, y = 0x3A, x = 0x15) -> vga_plot high for exactly one cycle at T+2 with x = 0x15, y = 0x3A, colour = 0; finished high at T+3. The same instruction with x = 0xA5 (165) produces no vga_plot, but finished still rises.
- MEMWRITE 0x2ABC_0010 followed by MEMREAD 0x1000_0010 -> mem_write pulses once with data 0x0ABC; the read returns 0x0ABC.
- Start held high for 10 cycles -> only one command executes; a second command starts only after start drops and rises again. Opcode 0xF -> no side effects, finished at T+3, result unchanged.
- Reset asserted at T+2 of a MEMREAD -> next cycle state is IDLE, finished = 1, result = 0, and the read is never captured.
